// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux_scan channel multiplexer.
//   state_t     : output FSM state (IDLE = no sample held, RUN = sample held)
//   MODE_*      : encodings of the mode input
//   clog2_min1  : select width, never less than one bit
package mux_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_scan_rr_next.sv
// Combinational round-robin search: finds the first set bit of mask_i strictly after
// ptr_i, wrapping modulo CHANNELS. ptr_i itself is the last candidate, so a lone
// enabled channel finds itself.
//   mask_i  : per-channel enable mask
//   ptr_i   : current position (must be < CHANNELS)
//   next_o  : index of the next enabled channel (0 when none found)
//   found_o : at least one channel is enabled
module rr_next
  import mux_scan_pkg::*;
#(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_BITS = clog2_min1(CHANNELS)
) (
  input  logic [CHANNELS-1:0] mask_i,
  input  logic [SEL_BITS-1:0] ptr_i,
  output logic [SEL_BITS-1:0] next_o,
  output logic                found_o
);

  localparam int N = int'(CHANNELS);

  // rot[k] is the enable of the channel k+1 positions after ptr_i.
  logic [CHANNELS-1:0] rot;
  logic [SEL_BITS-1:0] idx;

  always_comb begin
    rot = '0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx    = SEL_BITS'((int'(ptr_i) + k + 1) % N);
      rot[k] = mask_i[idx];
    end
  end

  // Priority encoder over the rotated mask: lowest k wins, so scan downwards.
  always_comb begin
    next_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        next_o = SEL_BITS'((int'(ptr_i) + k + 1) % N);
      end
    end
  end

  assign found_o = |rot;

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel multiplexer with manual and scan modes and a valid/ready output.
//   clk, rst_n : clock, asynchronous active-low reset
//   E          : packed channel words, channel i at E[i*INPUT_BITS +: INPUT_BITS]
//   ch_en      : per-channel enable mask
//   mode       : 0 = manual (use sel), 1 = scan enabled channels, DWELL samples each
//   sel        : manual channel select
//   ready      : downstream accepts F this cycle
//   F, ch_out  : registered sample and the channel it came from
//   valid      : F/ch_out hold a sample
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter int unsigned INPUT_BITS = 2,
  parameter int unsigned CHANNELS   = 8,
  parameter int unsigned SEL_BITS   = clog2_min1(CHANNELS),
  parameter int unsigned DWELL      = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*INPUT_BITS-1:0] E,
  input  logic [CHANNELS-1:0]            ch_en,
  input  logic                           mode,
  input  logic [SEL_BITS-1:0]            sel,
  input  logic                           ready,
  output logic [INPUT_BITS-1:0]          F,
  output logic [SEL_BITS-1:0]            ch_out,
  output logic                           valid
);

  // Every sel encoding gets a table slot; slots beyond CHANNELS read as disabled/zero,
  // which makes out-of-range manual selects ineligible without a separate compare.
  localparam int unsigned PadW     = 1 << SEL_BITS;
  localparam logic [7:0]  DwellMax = 8'(DWELL);

  logic [PadW-1:0]       en_pad;
  logic [INPUT_BITS-1:0] words [PadW];

  always_comb begin
    en_pad = PadW'(ch_en);
    for (int i = 0; i < int'(PadW); i++) begin
      words[i] = '0;
    end
    for (int i = 0; i < int'(CHANNELS); i++) begin
      words[i] = E[i*INPUT_BITS +: INPUT_BITS];
    end
  end

  state_t                state_q;
  logic [INPUT_BITS-1:0] f_q;
  logic [SEL_BITS-1:0]   ch_q;
  logic [SEL_BITS-1:0]   ptr_q;
  logic [7:0]            dwell_q;
  logic                  scan_q;  // mode seen at the previous load

  logic [SEL_BITS-1:0] rr_idx;
  logic                rr_found;

  rr_next #(
    .CHANNELS (CHANNELS),
    .SEL_BITS (SEL_BITS)
  ) u_rr_next (
    .mask_i  (ch_en),
    .ptr_i   (ptr_q),
    .next_o  (rr_idx),
    .found_o (rr_found)
  );

  logic                load;
  logic                stay;
  logic                elig;
  logic [SEL_BITS-1:0] tgt;

  always_comb begin
    load = (state_q == IDLE) || ready;
    stay = en_pad[ptr_q] && (dwell_q < DwellMax);
    if (mode == MODE_SCAN) begin
      tgt  = stay ? ptr_q : rr_idx;
      elig = rr_found;
    end else begin
      tgt  = sel;
      elig = en_pad[sel];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      f_q     <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
      dwell_q <= '0;
      scan_q  <= MODE_MANUAL;
    end else if (load) begin
      scan_q <= mode;
      if (elig) begin
        state_q <= RUN;
        f_q     <= words[tgt];
        ch_q    <= tgt;
        if (mode == MODE_SCAN) begin
          ptr_q <= tgt;
          // A fresh dwell starts on entering scan or whenever the search picked the
          // channel, including re-picking a lone enabled channel after its dwell.
          if (stay && (scan_q == MODE_SCAN)) begin
            dwell_q <= dwell_q + 8'd1;
          end else begin
            dwell_q <= 8'd1;
          end
        end
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign F      = f_q;
  assign ch_out = ch_q;
  assign valid  = (state_q == RUN);

endmodule
